riscv_ex_pipe: RTL and testbench



---
 rtl/riscv_pipe_pkg.sv | 16 +
 rtl/riscv_ex_pipe_slot.sv | 34 +++
 rtl/riscv_ex_pipe.sv | 112 +++++++++++
 tb/tb_riscv_ex_pipe.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// rtl/riscv_pipe_pkg.sv - shared constants and entry type for the execute pipe
// Contents: XLEN, REG_AW, TAG_W widths and ex_entry_t (result, rd, wen, tag).
package riscv_pipe_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int TAG_W  = 4;

  typedef struct packed {
    logic [XLEN-1:0]   result;
    logic [REG_AW-1:0] rd;
    logic              wen;
    logic [TAG_W-1:0]  tag;
  } ex_entry_t;

endpackage

// File: rtl/riscv_ex_pipe_slot.sv
// rtl/riscv_ex_pipe_slot.sv - one execute-pipe stage register
// Ports: clk, rst (sync, active-high), flush, load (stage may advance),
//        up_valid/up_entry (upstream stage or pipe input), valid/entry (stage contents).
module riscv_ex_pipe_slot
  import riscv_pipe_pkg::*;
#(
  parameter type entry_t = ex_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   load,
  input  logic   up_valid,
  input  entry_t up_entry,
  output logic   valid,
  output entry_t entry
);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= up_valid;
    end
  end

  // Payload is only meaningful while valid is set, so it carries no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      entry <= up_entry;
    end
  end

endmodule

// File: rtl/riscv_ex_pipe.sv
// rtl/riscv_ex_pipe.sv - elastic execute-stage pipeline with flush, occupancy and forwarding
// Ports: clk, rst (sync, active-high); in_valid/in_ready + in_result/in_rd/in_wen/in_tag;
//        out_valid/out_ready + out_result/out_rd/out_wen/out_tag; flush;
//        fwd_rs -> fwd_hit/fwd_data (youngest matching producer); occ (valid stage count).
module riscv_ex_pipe #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int TAG_W  = 4,
  parameter int DEPTH  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_result,
  input  logic [RD_W-1:0]            in_rd,
  input  logic                       in_wen,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_result,
  output logic [RD_W-1:0]            out_rd,
  output logic                       out_wen,
  output logic [TAG_W-1:0]           out_tag,
  input  logic                       flush,
  input  logic [RD_W-1:0]            fwd_rs,
  output logic                       fwd_hit,
  output logic [DATA_W-1:0]          fwd_data,
  output logic [$clog2(DEPTH+1)-1:0] occ
);

  import riscv_pipe_pkg::*;

  localparam int OCC_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [RD_W-1:0]   rd;
    logic              wen;
    logic [TAG_W-1:0]  tag;
  } entry_t;

  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] adv;
  entry_t           stage [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic   up_valid;
    entry_t up_entry;

    // A stage may advance if any stage from here to the output is empty or
    // the output is being taken; the flat AND avoids a ripple chain on adv.
    assign adv[i] = out_ready | ~(&valid[DEPTH-1:i]);

    if (i == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_entry = '{result: in_result, rd: in_rd, wen: in_wen, tag: in_tag};
    end else begin : g_body
      assign up_valid = valid[i-1];
      assign up_entry = stage[i-1];
    end

    riscv_ex_pipe_slot #(
      .entry_t (entry_t)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .load     (adv[i]),
      .up_valid (up_valid),
      .up_entry (up_entry),
      .valid    (valid[i]),
      .entry    (stage[i])
    );
  end

  assign in_ready   = adv[0];
  assign out_valid  = valid[DEPTH-1];
  assign out_result = stage[DEPTH-1].result;
  assign out_rd     = stage[DEPTH-1].rd;
  assign out_wen    = stage[DEPTH-1].wen;
  assign out_tag    = stage[DEPTH-1].tag;

  logic accept;
  logic deliver;

  assign accept  = in_valid & in_ready;
  assign deliver = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      occ <= '0;
    end else if (accept && !deliver) begin
      occ <= occ + OCC_W'(1);
    end else if (!accept && deliver) begin
      occ <= occ - OCC_W'(1);
    end
  end

  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (valid[i] && stage[i].wen && (stage[i].rd == fwd_rs) && (fwd_rs != '0)) begin
        fwd_hit  = 1'b1;
        fwd_data = stage[i].result;
      end
    end
  end

endmodule

// File: tb/tb_riscv_ex_pipe.sv
// tb/tb_riscv_ex_pipe.sv - self-checking bench for riscv_ex_pipe (DEPTH=3 and DEPTH=1)
module tb_riscv_ex_pipe;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DEPTH=3 instance
  logic        rst, in_valid, in_ready, in_wen, out_valid, out_ready, out_wen, flush, fwd_hit;
  logic [31:0] in_result, out_result, fwd_data;
  logic [4:0]  in_rd, out_rd, fwd_rs;
  logic [3:0]  in_tag, out_tag;
  logic [1:0]  occ;

  // DEPTH=1 instance
  logic        b_rst, b_in_valid, b_in_ready, b_in_wen, b_out_valid, b_out_ready, b_out_wen, b_flush, b_fwd_hit;
  logic [31:0] b_in_result, b_out_result, b_fwd_data;
  logic [4:0]  b_in_rd, b_out_rd, b_fwd_rs;
  logic [3:0]  b_in_tag, b_out_tag;
  logic [0:0]  b_occ;

  riscv_ex_pipe #(.DATA_W(32), .RD_W(5), .TAG_W(4), .DEPTH(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_rd(in_rd), .in_wen(in_wen), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_wen(out_wen), .out_tag(out_tag), .flush(flush),
    .fwd_rs(fwd_rs), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .occ(occ)
  );

  riscv_ex_pipe #(.DATA_W(32), .RD_W(5), .TAG_W(4), .DEPTH(1)) dut_b (
    .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_result(b_in_result), .in_rd(b_in_rd), .in_wen(b_in_wen), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_result(b_out_result),
    .out_rd(b_out_rd), .out_wen(b_out_wen), .out_tag(b_out_tag), .flush(b_flush),
    .fwd_rs(b_fwd_rs), .fwd_hit(b_fwd_hit), .fwd_data(b_fwd_data), .occ(b_occ)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic v, input logic [31:0] res, input logic [4:0] rd,
                      input logic wen, input logic [3:0] tag, input logic ordy, input logic fl);
    in_valid  = v;
    in_result = res;
    in_rd     = rd;
    in_wen    = wen;
    in_tag    = tag;
    out_ready = ordy;
    flush     = fl;
  endtask

  // Directed vectors: inputs for one cycle and outputs expected before that cycle's edge.
  typedef struct {
    logic        iv;
    logic [31:0] res;
    logic [3:0]  tag;
    logic        ordy;
    logic        e_ov;
    logic [31:0] e_res;
    logic [3:0]  e_tag;
    int          e_occ;
    logic        e_ir;
  } vec_t;

  vec_t vt[17];

  // Reference model: a row of DEPTH slots where each entry steps one slot
  // toward the output whenever the slot ahead is free.
  typedef struct packed {
    logic        rst;
    logic        in_valid;
    logic [31:0] result;
    logic [4:0]  rd;
    logic        wen;
    logic [3:0]  tag;
    logic        out_ready;
    logic        flush;
    logic [4:0]  fwd_rs;
  } pin_t;

  logic        mv   [2][8];
  logic [31:0] mres [2][8];
  logic [4:0]  mrd  [2][8];
  logic        mwen [2][8];
  logic [3:0]  mtag [2][8];

  task automatic model_clear(input int d);
    for (int k = 0; k < 8; k++) mv[d][k] = 1'b0;
  endtask

  task automatic model_cycle(input int d, input int dep, input pin_t p,
                             input logic a_ir, input logic a_ov, input logic [31:0] a_res,
                             input logic [4:0] a_rd, input logic a_wen, input logic [3:0] a_tag,
                             input logic a_hit, input logic [31:0] a_fd, input int a_occ);
    int          cnt;
    logic        e_ir;
    logic        e_hit;
    logic [31:0] e_fd;
    string       pre;
    pre = $sformatf("rand_d%0d", dep);
    cnt = 0;
    for (int k = 0; k < dep; k++) if (mv[d][k]) cnt++;
    e_ir  = (cnt < dep) || p.out_ready;
    e_hit = 1'b0;
    e_fd  = '0;
    for (int k = 0; k < dep; k++) begin
      if (!e_hit && mv[d][k] && mwen[d][k] && mrd[d][k] == p.fwd_rs && p.fwd_rs != 5'd0) begin
        e_hit = 1'b1;
        e_fd  = mres[d][k];
      end
    end
    chk({pre, " occ"}, 32'(a_occ), 32'(cnt));
    chk({pre, " in_ready"}, 32'(a_ir), 32'(e_ir));
    chk({pre, " out_valid"}, 32'(a_ov), 32'(mv[d][dep-1]));
    if (mv[d][dep-1]) begin
      chk({pre, " out_result"}, a_res, mres[d][dep-1]);
      chk({pre, " out_rd"}, 32'(a_rd), 32'(mrd[d][dep-1]));
      chk({pre, " out_wen"}, 32'(a_wen), 32'(mwen[d][dep-1]));
      chk({pre, " out_tag"}, 32'(a_tag), 32'(mtag[d][dep-1]));
    end
    chk({pre, " fwd_hit"}, 32'(a_hit), 32'(e_hit));
    chk({pre, " fwd_data"}, a_fd, e_fd);
    if (p.rst) begin
      model_clear(d);
    end else begin
      if (mv[d][dep-1] && p.out_ready) mv[d][dep-1] = 1'b0;
      for (int k = dep-2; k >= 0; k--) begin
        if (mv[d][k] && !mv[d][k+1]) begin
          mv[d][k+1]   = 1'b1;
          mres[d][k+1] = mres[d][k];
          mrd[d][k+1]  = mrd[d][k];
          mwen[d][k+1] = mwen[d][k];
          mtag[d][k+1] = mtag[d][k];
          mv[d][k]     = 1'b0;
        end
      end
      if (p.flush) begin
        model_clear(d);
      end else if (p.in_valid && e_ir) begin
        mv[d][0]   = 1'b1;
        mres[d][0] = p.result;
        mrd[d][0]  = p.rd;
        mwen[d][0] = p.wen;
        mtag[d][0] = p.tag;
      end
    end
  endtask

  function automatic pin_t rand_pin(input logic ordy);
    pin_t p;
    p.rst       = ($urandom_range(0, 99) == 0);
    p.in_valid  = ($urandom_range(0, 9) < 7);
    p.result    = $urandom;
    p.rd        = 5'($urandom_range(0, 7));
    p.wen       = ($urandom_range(0, 3) != 0);
    p.tag       = 4'($urandom);
    p.out_ready = ordy;
    p.flush     = ($urandom_range(0, 29) == 0);
    p.fwd_rs    = 5'($urandom_range(0, 7));
    return p;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    pin_t pa, pb;

    vt[0]  = '{1'b1, 32'h11, 4'd1, 1'b1, 1'b0, 32'h0,  4'd0, 0, 1'b1};
    vt[1]  = '{1'b1, 32'h22, 4'd2, 1'b1, 1'b0, 32'h0,  4'd0, 1, 1'b1};
    vt[2]  = '{1'b1, 32'h33, 4'd3, 1'b1, 1'b0, 32'h0,  4'd0, 2, 1'b1};
    vt[3]  = '{1'b0, 32'h0,  4'd0, 1'b1, 1'b1, 32'h11, 4'd1, 3, 1'b1};
    vt[4]  = '{1'b0, 32'h0,  4'd0, 1'b1, 1'b1, 32'h22, 4'd2, 2, 1'b1};
    vt[5]  = '{1'b0, 32'h0,  4'd0, 1'b1, 1'b1, 32'h33, 4'd3, 1, 1'b1};
    vt[6]  = '{1'b0, 32'h0,  4'd0, 1'b1, 1'b0, 32'h0,  4'd0, 0, 1'b1};
    vt[7]  = '{1'b1, 32'hA1, 4'd4, 1'b1, 1'b0, 32'h0,  4'd0, 0, 1'b1};
    vt[8]  = '{1'b0, 32'h0,  4'd0, 1'b1, 1'b0, 32'h0,  4'd0, 1, 1'b1};
    vt[9]  = '{1'b1, 32'hB2, 4'd6, 1'b1, 1'b0, 32'h0,  4'd0, 1, 1'b1};
    vt[10] = '{1'b0, 32'h0,  4'd0, 1'b0, 1'b1, 32'hA1, 4'd4, 2, 1'b1};
    vt[11] = '{1'b1, 32'hC3, 4'd7, 1'b0, 1'b1, 32'hA1, 4'd4, 2, 1'b1};
    vt[12] = '{1'b0, 32'h0,  4'd0, 1'b0, 1'b1, 32'hA1, 4'd4, 3, 1'b0};
    vt[13] = '{1'b0, 32'h0,  4'd0, 1'b1, 1'b1, 32'hA1, 4'd4, 3, 1'b1};
    vt[14] = '{1'b0, 32'h0,  4'd0, 1'b1, 1'b1, 32'hB2, 4'd6, 2, 1'b1};
    vt[15] = '{1'b0, 32'h0,  4'd0, 1'b1, 1'b1, 32'hC3, 4'd7, 1, 1'b1};
    vt[16] = '{1'b0, 32'h0,  4'd0, 1'b1, 1'b0, 32'h0,  4'd0, 0, 1'b1};

    rst = 1'b1;
    push(1'b0, 32'h0, 5'd0, 1'b0, 4'd0, 1'b1, 1'b0);
    fwd_rs = 5'd0;
    b_rst = 1'b1; b_in_valid = 1'b0; b_in_result = '0; b_in_rd = '0; b_in_wen = 1'b0;
    b_in_tag = '0; b_out_ready = 1'b0; b_flush = 1'b0; b_fwd_rs = '0;
    @(negedge clk);
    @(negedge clk);

    // Reset state
    rst = 1'b0;
    fwd_rs = 5'd7;
    #1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset occ", 32'(occ), 32'd0);
    chk("reset fwd_hit", 32'(fwd_hit), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    fwd_rs = 5'd0;

    // Streaming and backpressure/collapse table
    for (int i = 0; i < 17; i++) begin
      push(vt[i].iv, vt[i].res, 5'd1, 1'b0, vt[i].tag, vt[i].ordy, 1'b0);
      #1;
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vt[i].e_ov));
      chk($sformatf("vec%0d occ", i), 32'(occ), 32'(vt[i].e_occ));
      chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vt[i].e_ir));
      if (vt[i].e_ov) begin
        chk($sformatf("vec%0d out_result", i), out_result, vt[i].e_res);
        chk($sformatf("vec%0d out_tag", i), 32'(out_tag), 32'(vt[i].e_tag));
      end
      @(negedge clk);
    end

    // Flush with a full pipe: oldest still delivered, flush-cycle input dropped
    for (int i = 1; i <= 3; i++) begin
      push(1'b1, 32'(i), 5'd2, 1'b1, 4'(i), 1'b0, 1'b0);
      @(negedge clk);
    end
    push(1'b1, 32'h55, 5'd2, 1'b1, 4'd5, 1'b1, 1'b1);
    #1;
    chk("flush occ_before", 32'(occ), 32'd3);
    chk("flush delivered_valid", 32'(out_valid), 32'd1);
    chk("flush delivered_tag", 32'(out_tag), 32'd1);
    @(negedge clk);
    push(1'b0, 32'h0, 5'd0, 1'b0, 4'd0, 1'b1, 1'b0);
    #1;
    chk("flush after occ", 32'(occ), 32'd0);
    chk("flush after out_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("flush tag5_absent%0d", i), 32'(out_valid), 32'd0);
    end
    @(negedge clk);

    // Forwarding priority and filters
    push(1'b1, 32'hAAAA, 5'd7, 1'b1, 4'd1, 1'b0, 1'b0);
    @(negedge clk);
    push(1'b1, 32'h1234, 5'd3, 1'b0, 4'd2, 1'b0, 1'b0);
    @(negedge clk);
    push(1'b1, 32'hBBBB, 5'd7, 1'b1, 4'd3, 1'b0, 1'b0);
    fwd_rs = 5'd7;
    #1;
    chk("fwd single_hit", 32'(fwd_hit), 32'd1);
    chk("fwd single_data", fwd_data, 32'hAAAA);
    @(negedge clk);
    push(1'b0, 32'h0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    #1;
    chk("fwd youngest_hit", 32'(fwd_hit), 32'd1);
    chk("fwd youngest_data", fwd_data, 32'hBBBB);
    fwd_rs = 5'd3;
    #1;
    chk("fwd wen0_hit", 32'(fwd_hit), 32'd0);
    chk("fwd wen0_data", fwd_data, 32'd0);
    fwd_rs = 5'd5;
    #1;
    chk("fwd miss_hit", 32'(fwd_hit), 32'd0);
    flush = 1'b1;
    @(negedge clk);
    push(1'b1, 32'h5555, 5'd0, 1'b1, 4'd4, 1'b0, 1'b0);
    @(negedge clk);
    push(1'b0, 32'h0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    fwd_rs = 5'd0;
    #1;
    chk("fwd rd0_occ", 32'(occ), 32'd1);
    chk("fwd rd0_hit", 32'(fwd_hit), 32'd0);
    flush = 1'b1;
    @(negedge clk);

    // Reset mid-operation
    push(1'b1, 32'h91, 5'd9, 1'b1, 4'd1, 1'b0, 1'b0);
    @(negedge clk);
    push(1'b1, 32'h92, 5'd9, 1'b1, 4'd2, 1'b0, 1'b0);
    @(negedge clk);
    push(1'b1, 32'h93, 5'd9, 1'b1, 4'd3, 1'b0, 1'b0);
    fwd_rs = 5'd9;
    rst = 1'b1;
    #1;
    chk("rstmid occ_before", 32'(occ), 32'd2);
    @(negedge clk);
    rst = 1'b0;
    push(1'b0, 32'h0, 5'd0, 1'b0, 4'd0, 1'b1, 1'b0);
    #1;
    chk("rstmid out_valid", 32'(out_valid), 32'd0);
    chk("rstmid occ", 32'(occ), 32'd0);
    chk("rstmid fwd_hit", 32'(fwd_hit), 32'd0);
    push(1'b1, 32'h99, 5'd9, 1'b1, 4'd9, 1'b1, 1'b0);
    @(negedge clk);
    push(1'b0, 32'h0, 5'd0, 1'b0, 4'd0, 1'b1, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      #1;
      chk($sformatf("rstmid lat%0d out_valid", i), 32'(out_valid), 32'(i == 3));
      if (i == 3) chk("rstmid lat3 out_tag", 32'(out_tag), 32'd9);
      @(negedge clk);
    end

    // Randomized phase against the slot model, both depths
    rst = 1'b1;
    b_rst = 1'b1;
    @(negedge clk);
    model_clear(0);
    model_clear(1);
    for (int c = 0; c < 600; c++) begin
      pa = rand_pin($urandom_range(0, 3) != 0);
      pb = rand_pin(c[0]);
      rst = pa.rst; in_valid = pa.in_valid; in_result = pa.result; in_rd = pa.rd;
      in_wen = pa.wen; in_tag = pa.tag; out_ready = pa.out_ready; flush = pa.flush;
      fwd_rs = pa.fwd_rs;
      b_rst = pb.rst; b_in_valid = pb.in_valid; b_in_result = pb.result; b_in_rd = pb.rd;
      b_in_wen = pb.wen; b_in_tag = pb.tag; b_out_ready = pb.out_ready; b_flush = pb.flush;
      b_fwd_rs = pb.fwd_rs;
      #1;
      model_cycle(0, 3, pa, in_ready, out_valid, out_result, out_rd, out_wen, out_tag,
                  fwd_hit, fwd_data, int'(occ));
      model_cycle(1, 1, pb, b_in_ready, b_out_valid, b_out_result, b_out_rd, b_out_wen,
                  b_out_tag, b_fwd_hit, b_fwd_data, int'(b_occ));
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
